// File: rtl/inference_scheduler_pkg.sv
// Shared types and defaults for the inference scheduler: FSM encoding,
// channel/alarm defaults and the saturating run-counter helper.
package inference_scheduler_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_VOTE_W    = 6;
    localparam int DEF_ALARM_SET = 3;
    localparam int DEF_ALARM_CLR = 4;
    localparam int RUN_W         = 4;

    typedef logic [RUN_W-1:0] run_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_CAPT  = 2'd2
    } sched_state_t;

    function automatic run_t sat_inc(input run_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after 'last'
// (cyclic), returning both a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk from the farthest position to the nearest so the nearest requester
    // after 'last' is the one left in idx.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) idx = cand;
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/inference_scheduler.sv
// Round-robin scheduler sharing one classifier across NUM_CH sensor channels,
// with per-channel debounced anomaly alarms.
module inference_scheduler
    import inference_scheduler_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int VOTE_W    = DEF_VOTE_W,
    parameter int ALARM_SET = DEF_ALARM_SET,
    parameter int ALARM_CLR = DEF_ALARM_CLR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*DATA_W-1:0]   feat_accel_in,
    input  logic [NUM_CH*DATA_W-1:0]   feat_brake_in,
    output logic [NUM_CH-1:0]          req_ack,
    output logic                       cls_valid,
    output logic [DATA_W-1:0]          cls_accel,
    output logic [DATA_W-1:0]          cls_brake,
    input  logic [VOTE_W-1:0]          cls_vote,
    input  logic                       cls_anomaly,
    output logic                       res_valid,
    output logic [$clog2(NUM_CH)-1:0]  res_ch,
    output logic [VOTE_W-1:0]          res_vote,
    output logic                       res_anomaly,
    output logic [NUM_CH-1:0]          alarm,
    output logic                       alarm_any
);

    localparam int   CH_W   = $clog2(NUM_CH);
    localparam run_t SET_TH = run_t'(ALARM_SET);
    localparam run_t CLR_TH = run_t'(ALARM_CLR);

    sched_state_t state, state_nx;

    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] gnt_oh;
    logic              gnt_any;
    logic              grant_go;

    logic [NUM_CH-1:0][RUN_W-1:0] anom_run, anom_nx;
    logic [NUM_CH-1:0][RUN_W-1:0] clean_run, clean_nx;
    logic [NUM_CH-1:0]            alarm_nx;

    logic [DATA_W-1:0] accel_ch [NUM_CH];
    logic [DATA_W-1:0] brake_ch [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign accel_ch[i] = feat_accel_in[i*DATA_W +: DATA_W];
        assign brake_ch[i] = feat_brake_in[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (CH_W)
    ) u_arb (
        .req  (req),
        .last (last_grant),
        .gnt  (gnt_oh),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_comb begin
        state_nx = state;
        grant_go = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (enable && gnt_any) begin
                    grant_go = 1'b1;
                    state_nx = SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: state_nx = SCHED_CAPT;
            SCHED_CAPT:  state_nx = SCHED_IDLE;
            default:     state_nx = SCHED_IDLE;
        endcase
    end

    // Only the channel whose result is being captured moves; clear wins over it.
    always_comb begin
        anom_nx  = anom_run;
        clean_nx = clean_run;
        alarm_nx = alarm;
        if (clear) begin
            anom_nx  = '0;
            clean_nx = '0;
            alarm_nx = '0;
        end else if (state == SCHED_CAPT) begin
            if (cls_anomaly) begin
                anom_nx[last_grant]  = sat_inc(anom_run[last_grant]);
                clean_nx[last_grant] = '0;
                if (anom_nx[last_grant] >= SET_TH) alarm_nx[last_grant] = 1'b1;
            end else begin
                clean_nx[last_grant] = sat_inc(clean_run[last_grant]);
                anom_nx[last_grant]  = '0;
                if (clean_nx[last_grant] >= CLR_TH) alarm_nx[last_grant] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCHED_IDLE;
            last_grant  <= CH_W'(NUM_CH - 1);
            req_ack     <= '0;
            cls_valid   <= 1'b0;
            cls_accel   <= '0;
            cls_brake   <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_vote    <= '0;
            res_anomaly <= 1'b0;
            alarm       <= '0;
            alarm_any   <= 1'b0;
            anom_run    <= '0;
            clean_run   <= '0;
        end else begin
            state     <= state_nx;
            req_ack   <= grant_go ? gnt_oh : '0;
            // The classifier sees data_valid in the cycle after the ack cycle.
            cls_valid <= (state == SCHED_ISSUE);
            res_valid <= (state == SCHED_CAPT);
            if (grant_go) begin
                last_grant <= gnt_idx;
                cls_accel  <= accel_ch[gnt_idx];
                cls_brake  <= brake_ch[gnt_idx];
            end
            if (state == SCHED_CAPT) begin
                res_ch      <= last_grant;
                res_vote    <= cls_vote;
                res_anomaly <= cls_anomaly;
            end
            anom_run  <= anom_nx;
            clean_run <= clean_nx;
            alarm     <= alarm_nx;
            alarm_any <= |alarm_nx;
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Self-checking bench for inference_scheduler: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_inference_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] fa [4];
    logic [15:0] fb [4];
    logic [63:0] feat_accel_in, feat_brake_in;
    logic [3:0]  req_ack;
    logic        cls_valid;
    logic [15:0] cls_accel, cls_brake;
    logic [5:0]  cls_vote;
    logic        cls_anomaly;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [5:0]  res_vote;
    logic        res_anomaly;
    logic [3:0]  alarm;
    logic        alarm_any;
    logic [3:0]  hold = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign feat_accel_in = {fa[3], fa[2], fa[1], fa[0]};
    assign feat_brake_in = {fb[3], fb[2], fb[1], fb[0]};

    // Stand-in classifier: vote is a sum of low bits, anomaly is accel MSB.
    function automatic logic [5:0] vote_of(input logic [15:0] a, input logic [15:0] b);
        return a[5:0] + b[5:0];
    endfunction
    assign cls_vote    = vote_of(cls_accel, cls_brake);
    assign cls_anomaly = cls_accel[15];

    inference_scheduler #(
        .NUM_CH(4), .DATA_W(16), .VOTE_W(6), .ALARM_SET(3), .ALARM_CLR(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .req(req),
        .feat_accel_in(feat_accel_in), .feat_brake_in(feat_brake_in),
        .req_ack(req_ack), .cls_valid(cls_valid), .cls_accel(cls_accel),
        .cls_brake(cls_brake), .cls_vote(cls_vote), .cls_anomaly(cls_anomaly),
        .res_valid(res_valid), .res_ch(res_ch), .res_vote(res_vote),
        .res_anomaly(res_anomaly), .alarm(alarm), .alarm_any(alarm_any)
    );

    // Reference model: m_phase counts cycles since a grant (0 = free).
    int          m_phase, m_last, m_rch, ph_prev, pick;
    logic [15:0] m_accel, m_brake;
    logic [3:0]  m_ack, m_alarm;
    logic        m_rv, m_ranom, m_any;
    logic [5:0]  m_rvote;
    int          m_anom [4];
    int          m_clean [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_last = 3; m_rch = 0;
            m_accel = '0; m_brake = '0; m_ack = '0; m_rv = 1'b0;
            m_rvote = '0; m_ranom = 1'b0; m_alarm = '0;
            for (int i = 0; i < 4; i++) begin m_anom[i] = 0; m_clean[i] = 0; end
        end else begin
            ph_prev = m_phase;
            m_ack = '0;
            m_rv = 1'b0;
            if (ph_prev == 2) begin
                m_rv = 1'b1;
                m_rch = m_last;
                m_rvote = vote_of(m_accel, m_brake);
                m_ranom = m_accel[15];
                if (m_ranom) begin
                    m_anom[m_rch] = (m_anom[m_rch] >= 15) ? 15 : m_anom[m_rch] + 1;
                    m_clean[m_rch] = 0;
                    if (m_anom[m_rch] >= 3) m_alarm[m_rch] = 1'b1;
                end else begin
                    m_clean[m_rch] = (m_clean[m_rch] >= 15) ? 15 : m_clean[m_rch] + 1;
                    m_anom[m_rch] = 0;
                    if (m_clean[m_rch] >= 4) m_alarm[m_rch] = 1'b0;
                end
            end
            if (clear) begin
                m_alarm = '0;
                for (int i = 0; i < 4; i++) begin m_anom[i] = 0; m_clean[i] = 0; end
            end
            if (ph_prev == 0 && enable && req != 0) begin
                pick = -1;
                for (int k = 1; k <= 4; k++)
                    if (pick < 0 && req[(m_last + k) % 4]) pick = (m_last + k) % 4;
                m_ack[pick] = 1'b1;
                m_accel = fa[pick];
                m_brake = fb[pick];
                m_last = pick;
                m_phase = 1;
            end else if (ph_prev == 1) begin
                m_phase = 2;
            end else if (ph_prev == 2) begin
                m_phase = 0;
            end
        end
        m_any = |m_alarm;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("req_ack",     32'(req_ack),     32'(m_ack));
        chk("cls_valid",   32'(cls_valid),   32'(m_phase == 2));
        chk("cls_accel",   32'(cls_accel),   32'(m_accel));
        chk("cls_brake",   32'(cls_brake),   32'(m_brake));
        chk("res_valid",   32'(res_valid),   32'(m_rv));
        chk("res_ch",      32'(res_ch),      32'(m_rch));
        chk("res_vote",    32'(res_vote),    32'(m_rvote));
        chk("res_anomaly", 32'(res_anomaly), 32'(m_ranom));
        chk("alarm",       32'(alarm),       32'(m_alarm));
        chk("alarm_any",   32'(alarm_any),   32'(m_any));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
        for (int i = 0; i < 4; i++)
            if (req_ack[i] && !hold[i]) req[i] = 1'b0;
    endtask

    task automatic do_txn(input int ch, input bit anom, input bit clr);
        bit done;
        done = 1'b0;
        fa[ch] = {anom, 15'($urandom)};
        fb[ch] = 16'($urandom);
        req[ch] = 1'b1;
        for (int n = 0; n < 12 && !done; n++) begin
            if (clr && cls_valid) clear = 1'b1;
            tick();
            clear = 1'b0;
            if (res_valid) done = 1'b1;
        end
        chk("txn_done", 32'(done), 32'd1);
    endtask

    int ack_cnt, rv_cnt, exp_g, got_g;
    bit seen;

    initial begin
        for (int i = 0; i < 4; i++) begin fa[i] = '0; fb[i] = '0; end
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_outs", 32'({req_ack, cls_valid, res_valid, alarm, alarm_any}), 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // single request, ch0, known vote
        fa[0] = 16'hC02D; fb[0] = 16'h0000; req = 4'b0001;
        tick();
        chk("single_ack", 32'(req_ack), 32'h1);
        seen = 1'b0;
        for (int n = 0; n < 6 && !seen; n++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        chk("single_seen", 32'(seen), 32'd1);
        chk("single_ch", 32'(res_ch), 32'd0);
        chk("single_vote", 32'(res_vote), 32'd45);
        chk("single_anom", 32'(res_anomaly), 32'd1);
        tick();

        // fairness: all held; last grant was ch0 so order is 1,2,3,0
        for (int i = 0; i < 4; i++) fa[i] = 16'h0100 + 16'(i);
        hold = 4'hF; req = 4'hF;
        ack_cnt = 0; rv_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (res_valid) rv_cnt++;
            if (req_ack != 0) begin
                exp_g = (ack_cnt + 1) % 4;
                got_g = 0;
                for (int i = 0; i < 4; i++) if (req_ack[i]) got_g = i;
                chk("fair_order", 32'(got_g), 32'(exp_g));
                ack_cnt++;
            end
        end
        chk("fair_acks", 32'(ack_cnt), 32'd4);
        chk("fair_results", 32'(rv_cnt), 32'd4);
        hold = '0; req = '0;
        repeat (3) tick();

        // debounce set / clear on ch2
        do_txn(2, 1, 0); do_txn(2, 1, 0);
        chk("deb_pre_set", 32'(alarm[2]), 32'd0);
        do_txn(2, 1, 0);
        chk("deb_set", 32'(alarm[2]), 32'd1);
        chk("deb_any_set", 32'(alarm_any), 32'd1);
        do_txn(2, 0, 0); do_txn(2, 0, 0); do_txn(2, 0, 0);
        chk("deb_hold", 32'(alarm[2]), 32'd1);
        do_txn(2, 0, 0);
        chk("deb_clr", 32'(alarm[2]), 32'd0);
        chk("deb_any_clr", 32'(alarm_any), 32'd0);

        // interrupted anomaly run on ch1 never alarms
        do_txn(1, 1, 0); do_txn(1, 1, 0); do_txn(1, 0, 0);
        do_txn(1, 1, 0); do_txn(1, 1, 0);
        chk("interleave", 32'(alarm[1]), 32'd0);

        // enable gating
        enable = 1'b0; fa[1] = 16'h1234; req = 4'b0010;
        repeat (3) begin
            tick();
            chk("en_low_ack", 32'(req_ack), 32'd0);
        end
        enable = 1'b1;
        tick();
        chk("en_grant", 32'(req_ack), 32'b0010);
        enable = 1'b0;
        tick();
        tick();
        chk("en_drop_res", 32'(res_valid), 32'd1);
        enable = 1'b1;
        tick();

        // clear during CAPT of an anomaly on an alarmed channel
        do_txn(3, 1, 0); do_txn(3, 1, 0); do_txn(3, 1, 0);
        chk("clr_pre", 32'(alarm[3]), 32'd1);
        do_txn(3, 1, 1);
        chk("clr_res", 32'(res_valid), 32'd1);
        chk("clr_alarm", 32'(alarm), 32'd0);
        do_txn(3, 1, 0); do_txn(3, 1, 0);
        chk("clr_cnt_zero", 32'(alarm[3]), 32'd0);
        do_txn(3, 1, 0);
        chk("clr_reset", 32'(alarm[3]), 32'd1);

        // reset in CAPT abandons the transaction
        fa[2] = 16'h8001; req = 4'b0100;
        for (int n = 0; n < 8 && !cls_valid; n++) tick();
        chk("rst_capt", 32'(cls_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_all();
        chk("rst_mid", 32'({req_ack, cls_valid, res_valid, alarm, alarm_any}), 32'd0);
        req = 4'b0101;
        @(negedge clk);
        chk("rst_no_res", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant", 32'(req_ack), 32'b0001);
        repeat (8) tick();

        // randomized traffic
        hold = 4'hF; req = '0;
        for (int n = 0; n < 1500; n++) begin
            enable = ($urandom % 10) != 0;
            clear  = ($urandom % 40) == 0;
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i]) begin
                    if ($urandom % 2 == 0) req[i] = 1'b0;
                    else begin fa[i] = 16'($urandom); fb[i] = 16'($urandom); end
                end else if (!req[i] && ($urandom % 3) == 0) begin
                    req[i] = 1'b1;
                    fa[i] = 16'($urandom);
                    fb[i] = 16'($urandom);
                end
            end
            tick();
        end
        hold = '0; req = '0; clear = 1'b0; enable = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
